// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - PC select, pipeline enable/flush sequencing and redirect/stall counters
module fetch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             id_jr,
  input  logic             id_jal,
  input  logic             id_load_use,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic [1:0]       pc_sel,
  output logic             pc_en,
  output logic             pipe_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       mem_stall;
  logic       redirect;
  logic       stall_inc;

  assign mem_stall = icache_stall | dcache_stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    pc_sel       = 2'b00;
    pc_en        = 1'b0;
    pipe_en      = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    redirect     = 1'b0;
    stall_inc    = 1'b0;
    if (RST) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_stall) begin
      stall_inc = 1'b1;
    end else if (state == RUN) begin
      pipe_en = 1'b1;
      pc_en   = 1'b1;
      // Oldest instruction wins: EX branch outranks the younger ID jumps.
      if (ex_branch && ex_taken) begin
        pc_sel       = 2'b01;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        redirect     = 1'b1;
      end else if (id_jr) begin
        pc_sel      = 2'b10;
        if_id_flush = 1'b1;
        redirect    = 1'b1;
      end else if (id_jal) begin
        pc_sel      = 2'b11;
        if_id_flush = 1'b1;
        redirect    = 1'b1;
      end else if (id_load_use) begin
        pc_en        = 1'b0;
        id_ex_bubble = 1'b1;
        stall_inc    = 1'b1;
      end
      if (redirect) begin
        state_nxt = FLUSH;
        fcnt_nxt  = FLUSH_INIT;
      end
    end else begin
      pipe_en      = 1'b1;
      pc_en        = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fcnt_nxt     = fcnt - 3'd1;
      if (fcnt <= 3'd1) begin
        state_nxt = RUN;
        fcnt_nxt  = 3'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (redirect && redirect_cnt != CNT_MAX) redirect_cnt <= redirect_cnt + CNT_ONE;
      if (stall_inc && stall_cnt != CNT_MAX)   stall_cnt    <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl (two parameterisations)
module tb_fetch_redirect_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ex_branch = 1'b0, ex_taken = 1'b0, id_jr = 1'b0, id_jal = 1'b0;
  logic id_load_use = 1'b0, icache_stall = 1'b0, dcache_stall = 1'b0;

  logic [1:0]  pc_sel_a, pc_sel_b;
  logic        pc_en_a, pipe_en_a, flush_a, bubble_a;
  logic        pc_en_b, pipe_en_b, flush_b, bubble_b;
  logic [31:0] rcnt_a, scnt_a;
  logic [3:0]  rcnt_b, scnt_b;

  always #5 CLK = ~CLK;

  fetch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
    .CLK(CLK), .RST(RST), .ex_branch(ex_branch), .ex_taken(ex_taken), .id_jr(id_jr),
    .id_jal(id_jal), .id_load_use(id_load_use), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .pc_sel(pc_sel_a), .pc_en(pc_en_a), .pipe_en(pipe_en_a),
    .if_id_flush(flush_a), .id_ex_bubble(bubble_a), .redirect_cnt(rcnt_a), .stall_cnt(scnt_a));

  fetch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .ex_branch(ex_branch), .ex_taken(ex_taken), .id_jr(id_jr),
    .id_jal(id_jal), .id_load_use(id_load_use), .icache_stall(icache_stall),
    .dcache_stall(dcache_stall), .pc_sel(pc_sel_b), .pc_en(pc_en_b), .pipe_en(pipe_en_b),
    .if_id_flush(flush_b), .id_ex_bubble(bubble_b), .redirect_cnt(rcnt_b), .stall_cnt(scnt_b));

  // ctl = {pc_sel, pc_en, pipe_en, if_id_flush, id_ex_bubble}; rc/sc < 0 skips counters.
  typedef struct {
    bit         which;
    logic [5:0] ctl;
    int         rc;
    int         sc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [5:0] act;
      int         arc, asc;
      e = sb.pop_front();
      if (e.which) begin
        act = {pc_sel_b, pc_en_b, pipe_en_b, flush_b, bubble_b};
        arc = int'(32'(rcnt_b));
        asc = int'(32'(scnt_b));
      end else begin
        act = {pc_sel_a, pc_en_a, pipe_en_a, flush_a, bubble_a};
        arc = int'(rcnt_a);
        asc = int'(scnt_a);
      end
      n_checks++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      if (e.rc >= 0) begin
        n_checks++;
        if (arc != e.rc || asc != e.sc) begin
          n_fail++;
          $display("FAIL %s counters: got rc=%0d sc=%0d expected rc=%0d sc=%0d",
                   e.name, arc, asc, e.rc, e.sc);
        end
      end
    end
  end

  // in = {RST, ex_branch, ex_taken, id_jr, id_jal, id_load_use, icache_stall, dcache_stall}
  task automatic vec(input logic [7:0] in, input bit which, input logic [5:0] ctl,
                     input int rc, input int sc, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    {RST, ex_branch, ex_taken, id_jr, id_jal, id_load_use, icache_stall, dcache_stall} = in;
    e.which = which; e.ctl = ctl; e.rc = rc; e.sc = sc; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    // FLUSH_CYCLES=1, CNT_W=32 instance
    vec(8'b1000_0000, 0, 6'b000011, 0, 0, "a_rst1");
    vec(8'b1000_0000, 0, 6'b000011, 0, 0, "a_rst2");
    vec(8'b0000_0000, 0, 6'b001100, 0, 0, "a_release");
    vec(8'b0110_1000, 0, 6'b011111, 0, 0, "a_br_vs_jal");
    vec(8'b0000_1000, 0, 6'b001111, 1, 0, "a_flush_jal_masked");
    vec(8'b0000_0000, 0, 6'b001100, 1, 0, "a_back_run");
    vec(8'b0101_0000, 0, 6'b101110, 1, 0, "a_nottaken_jr");
    vec(8'b0000_0000, 0, 6'b001111, 2, 0, "a_jr_flush");
    vec(8'b0000_0100, 0, 6'b000101, 2, 0, "a_load_use");
    vec(8'b0000_0000, 0, 6'b001100, 2, 1, "a_after_lu");
    vec(8'b0000_0001, 0, 6'b000000, 2, 1, "a_dstall");
    vec(8'b0000_0000, 0, 6'b001100, 2, 2, "a_after_dstall");
    vec(8'b0001_0100, 0, 6'b101110, 2, 2, "a_jr_vs_lu");
    vec(8'b0000_0000, 0, 6'b001111, 3, 2, "a_flush2");
    vec(8'b0000_0000, 0, 6'b001100, 3, 2, "a_run2");
    vec(8'b0110_0001, 0, 6'b000000, 3, 2, "a_br_during_stall");
    vec(8'b0000_0000, 0, 6'b001100, 3, 3, "a_no_accept");

    // FLUSH_CYCLES=2, CNT_W=4 instance
    vec(8'b1000_0000, 1, 6'b000011, -1, -1, "b_rst1");
    vec(8'b1000_0000, 1, 6'b000011, 0, 0, "b_rst2");
    vec(8'b0110_0000, 1, 6'b011111, 0, 0, "b_branch");
    vec(8'b0000_0010, 1, 6'b000000, 1, 0, "b_istall1");
    vec(8'b0000_0010, 1, 6'b000000, 1, 1, "b_istall2");
    vec(8'b0000_0010, 1, 6'b000000, 1, 2, "b_istall3");
    vec(8'b0001_0000, 1, 6'b001111, 1, 3, "b_flush1_jr_masked");
    vec(8'b0000_0000, 1, 6'b001111, 1, 3, "b_flush2");
    vec(8'b0000_0000, 1, 6'b001100, 1, 3, "b_run");
    for (int i = 0; i < 20; i++) begin
      vec(8'b0000_1000, 1, 6'b111110, (1 + i > 15) ? 15 : 1 + i, 3, "b_sat_jal");
      vec(8'b0000_0000, 1, 6'b001111, (2 + i > 15) ? 15 : 2 + i, 3, "b_sat_flush1");
      vec(8'b0000_0000, 1, 6'b001111, (2 + i > 15) ? 15 : 2 + i, 3, "b_sat_flush2");
    end
    vec(8'b0000_0000, 1, 6'b001100, 15, 3, "b_saturated");
    vec(8'b0001_0000, 1, 6'b101110, 15, 3, "b_jr_at_max");
    vec(8'b0000_0000, 1, 6'b001111, 15, 3, "b_flush_before_rst");
    vec(8'b1000_0000, 1, 6'b000011, 15, 3, "b_rst_mid_flush");
    vec(8'b0000_0000, 1, 6'b001100, 0, 0, "b_run_after_rst");
    vec(8'b0000_0000, 1, 6'b001100, 0, 0, "b_run_idle");

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge CLK);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
